cache_ctrl_param: RTL
=====================

CACHE_CTRL_PARAM -- requirements
Module: cache_ctrl_param

Interface
REQ-001 Parameter WAIT_CYCLES, 4, memory wait cycles per beat; legal 1..255.
REQ-002 Parameter LINE_BEATS, 1, memory beats per line fill; power of two, 1..16.
REQ-003 Port clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Port Strobe  in  1  CPU request; sampled only in IDLE.
REQ-006 Port DRW  in  1  request direction; 0 = read, 1 = write.
REQ-007 Port M  in  1  tag match from tag array.
REQ-008 Port V  in  1  valid bit from tag array.
REQ-009 Port DReady  out  1  one-cycle completion pulse to CPU.
REQ-010 Port W  out  1  cache data/tag write enable.
REQ-011 Port MStrobe  out  1  one-cycle memory request pulse, issued per beat.
REQ-012 Port MRW  out  1  memory direction; 0 = read, 1 = write.
REQ-013 Port RSel  out  1  CPU read-data mux; 1 = memory data.
REQ-014 Port WSel  out  1  cache write-data mux; 0 = CPU data, 1 = memory data.
REQ-015 Port BeatIdx  out  max(1,$clog2(LINE_BEATS))  current fill beat, drives cache word address.
REQ-016 Port Busy  out  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, READ, READ_MISS, READ_MEM, READ_DATA, WRITE, WRITE_MEM, WRITE_DATA; outputs are combinational from state, M, V and counters.
REQ-018 IDLE: all outputs 0; Strobe&~DRW -> READ; Strobe&DRW -> WRITE; else stay.
REQ-019 READ: hit = M&V; on hit DReady=1, next IDLE (hit latency: DReady 1 cycle after Strobe sampled); on miss next READ_MISS.
REQ-020 READ_MISS: MStrobe=1, MRW=0; BeatIdx cleared to 0; wait counter loaded with WAIT_CYCLES-1; next READ_MEM.
REQ-021 READ_MEM: RSel=1, WSel=1, MRW=0; counter decrements each cycle; at counter 0 next READ_DATA (exactly WAIT_CYCLES cycles in state).
REQ-022 READ_DATA: W=1, RSel=1, WSel=1; if BeatIdx==LINE_BEATS-1 then DReady=1, next IDLE; else BeatIdx+1, MStrobe=1, counter reloaded, next READ_MEM.
REQ-023 Read-miss DReady cycle after Strobe sample = 2 + LINE_BEATS*(WAIT_CYCLES+1).
REQ-024 WRITE (write-through): W = M&V, WSel=0; MStrobe=1, MRW=1; counter loaded WAIT_CYCLES-1; next WRITE_MEM.
REQ-025 WRITE_MEM: MRW=1; counter decrements; at 0 next WRITE_DATA.
REQ-026 WRITE_DATA: DReady=1, MRW=1; next IDLE; write DReady at cycle 2+WAIT_CYCLES.
REQ-027 Strobe/DRW changes outside IDLE are ignored; an accepted request always completes.
REQ-028 Strobe held high through DReady: new request accepted after exactly one IDLE cycle.
REQ-029 BeatIdx wraps never; it holds its value in IDLE until the next READ_MISS clears it.
REQ-030 Undefined state encodings return to IDLE next cycle with all outputs 0.

Reset
REQ-031 reset low asynchronously forces IDLE, counter 0, BeatIdx 0, all outputs 0, including mid-fill or mid-write; no DReady is produced for the aborted request.

Configuration
REQ-032 Macro CACHE_CTRL_WRITE_ALLOCATE_EN defined: write miss in WRITE goes to READ_MISS with an internal allocate flag set, no memory write that cycle; fill proceeds per REQ-020..022 but final READ_DATA asserts no DReady and returns to WRITE, flag cleared; write then completes per REQ-024..026.
REQ-033 Macro undefined: write miss is no-allocate (W=0 in WRITE), allocate flag and its logic absent.

Structure
REQ-034 Package cache_ctrl_pkg holds the state enum typedef and default WAIT_CYCLES/LINE_BEATS constants.
REQ-035 Sub-module wait_cnt: parametrised loadable down-counter with load, value, zero flag; one instance.

Verification
REQ-036 Read hit: Strobe=1, DRW=0, M=V=1 -> DReady at cycle 1, MStrobe never high.
REQ-037 Read miss, WAIT_CYCLES=4, LINE_BEATS=1 -> MStrobe at cycle 2, W at cycle 7, DReady at cycle 7.
REQ-038 Read miss, WAIT_CYCLES=2, LINE_BEATS=4 -> 4 MStrobe pulses, BeatIdx 0..3, DReady at cycle 14.
REQ-039 Write hit, WAIT_CYCLES=4 -> W=1 and MStrobe=1, MRW=1 at cycle 1, DReady at cycle 6; with macro, write miss -> fill then write, single DReady.
REQ-040 reset low during READ_MEM -> all outputs 0 immediately, IDLE; next read completes with normal latency.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types and default sizing for the cache controller slice.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ       = 3'd1,
    READ_MISS  = 3'd2,
    READ_MEM   = 3'd3,
    READ_DATA  = 3'd4,
    WRITE      = 3'd5,
    WRITE_MEM  = 3'd6,
    WRITE_DATA = 3'd7
  } state_e;

  localparam int DEFAULT_WAIT_CYCLES = 4;
  localparam int DEFAULT_LINE_BEATS  = 1;
  localparam int CNT_W               = 8;

endpackage

// File: rtl/cache_ctrl_param_wait_cnt.sv
// Loadable down-counter that paces memory beats; saturates at zero.
module wait_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/cache_ctrl_param.sv
// Cache controller FSM: read hit/miss with multi-beat fill, write-through writes.
// Optional write-allocate on write miss via `define CACHE_CTRL_WRITE_ALLOCATE_EN.
module cache_ctrl_param
  import cache_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int LINE_BEATS  = DEFAULT_LINE_BEATS
) (
  input  logic clk,
  input  logic reset,
  input  logic Strobe,
  input  logic DRW,
  input  logic M,
  input  logic V,
  output logic DReady,
  output logic W,
  output logic MStrobe,
  output logic MRW,
  output logic RSel,
  output logic WSel,
  output logic [((LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1)-1:0] BeatIdx,
  output logic Busy
);

  localparam int BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [BW-1:0]    LAST_BEAT = BW'(LINE_BEATS - 1);
  localparam logic [CNT_W-1:0] RELOAD    = CNT_W'(WAIT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] beatIdx_q, beatIdx_d;
  logic          cntLoad, cntDec, cntZero;
  logic          hit;
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
  logic          alloc_q, alloc_d;
`endif

  assign hit     = M & V;
  assign BeatIdx = beatIdx_q;

  wait_cnt #(.WIDTH(CNT_W)) u_wait_cnt (
    .clk     (clk),
    .reset   (reset),
    .load_i  (cntLoad),
    .dec_i   (cntDec),
    .value_i (RELOAD),
    .zero_o  (cntZero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      beatIdx_q <= '0;
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
      alloc_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      beatIdx_q <= beatIdx_d;
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
      alloc_q   <= alloc_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    beatIdx_d = beatIdx_q;
    cntLoad   = 1'b0;
    cntDec    = 1'b0;
    DReady    = 1'b0;
    W         = 1'b0;
    MStrobe   = 1'b0;
    MRW       = 1'b0;
    RSel      = 1'b0;
    WSel      = 1'b0;
    Busy      = 1'b1;
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
    alloc_d   = alloc_q;
`endif
    case (state_q)
      IDLE: begin
        Busy = 1'b0;
        if (Strobe) begin
          state_d = DRW ? WRITE : READ;
        end
      end
      READ: begin
        if (hit) begin
          DReady  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = READ_MISS;
        end
      end
      READ_MISS: begin
        MStrobe   = 1'b1;
        beatIdx_d = '0;
        cntLoad   = 1'b1;
        state_d   = READ_MEM;
      end
      READ_MEM: begin
        RSel   = 1'b1;
        WSel   = 1'b1;
        cntDec = 1'b1;
        if (cntZero) begin
          state_d = READ_DATA;
        end
      end
      READ_DATA: begin
        W    = 1'b1;
        RSel = 1'b1;
        WSel = 1'b1;
        if (beatIdx_q == LAST_BEAT) begin
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
          // An allocating fill hands control back to the pending write instead of the CPU.
          if (alloc_q) begin
            alloc_d = 1'b0;
            state_d = WRITE;
          end else begin
            DReady  = 1'b1;
            state_d = IDLE;
          end
`else
          DReady  = 1'b1;
          state_d = IDLE;
`endif
        end else begin
          beatIdx_d = beatIdx_q + 1'b1;
          MStrobe   = 1'b1;
          cntLoad   = 1'b1;
          state_d   = READ_MEM;
        end
      end
      WRITE: begin
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
        if (!hit) begin
          alloc_d = 1'b1;
          state_d = READ_MISS;
        end else begin
          W       = 1'b1;
          MStrobe = 1'b1;
          MRW     = 1'b1;
          cntLoad = 1'b1;
          state_d = WRITE_MEM;
        end
`else
        W       = hit;
        MStrobe = 1'b1;
        MRW     = 1'b1;
        cntLoad = 1'b1;
        state_d = WRITE_MEM;
`endif
      end
      WRITE_MEM: begin
        MRW    = 1'b1;
        cntDec = 1'b1;
        if (cntZero) begin
          state_d = WRITE_DATA;
        end
      end
      WRITE_DATA: begin
        DReady  = 1'b1;
        MRW     = 1'b1;
        state_d = IDLE;
      end
      default: begin
        Busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule
